reg_writeback: RTL and testbench

//  Write side of the 4-entry register file. Takes results from the ALU and load paths,

---
 rtl/reg_writeback_pkg.sv | 27 ++
 rtl/reg_writeback_queue.sv | 81 ++++++++
 rtl/reg_writeback.sv | 141 ++++++++++++++
 tb/tb_reg_writeback.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file write-back path.
//   SIZE_WORD   data width of a register-file word
//   SIZE_REG    number of architectural registers (one pending bit each)
//   REG_ADDR_W  register address width
//   WB_DEPTH    default depth of the write-back queue
//   wbEntry_t   queue entry layout {valid, regIdx, data}
package reg_writeback_pkg;

    localparam int SIZE_WORD  = 16;
    localparam int SIZE_REG   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] regIdx;
        logic [SIZE_WORD-1:0]  data;
    } wbEntry_t;

    function automatic logic [SIZE_REG-1:0] regOneHot(input logic [REG_ADDR_W-1:0] r);
        logic [SIZE_REG-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_writeback_queue.sv
// In-order circular buffer for write-back entries.
// Accepts up to two pushes per cycle (push1 lands behind push0; push1 is only
// asserted together with push0) and one pop from the head.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push0/pushEntry0      first entry written this cycle
//   push1/pushEntry1      second entry written this cycle
//   pop                   retire the head entry
//   head                  current head entry (valid=0 when empty)
//   entryValid/entryReg   per-slot valid bit and destination register
//   count                 occupied entries
//   rdPtr, entryData      head slot index and per-slot data (WB_BYPASS_EN builds only)
module wb_queue
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push0,
    input  wbEntry_t                              pushEntry0,
    input  logic                                  push1,
    input  wbEntry_t                              pushEntry1,
    input  logic                                  pop,
    output wbEntry_t                              head,
    output logic [DEPTH-1:0]                      entryValid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entryReg,
    output logic [PTR_W:0]                        count
`ifdef WB_BYPASS_EN
    ,
    output logic [PTR_W-1:0]                      rdPtr,
    output logic [DEPTH-1:0][SIZE_WORD-1:0]       entryData
`endif
);

    wbEntry_t [DEPTH-1:0] slots;
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtrQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            slots  <= '0;
            wrPtr  <= '0;
            rdPtrQ <= '0;
            count  <= '0;
        end else begin
            // Invalidate before writing: when full, a push may reuse the slot
            // being popped this cycle and must end up valid.
            if (pop) begin
                slots[rdPtrQ].valid <= 1'b0;
                rdPtrQ              <= rdPtrQ + PTR_W'(1);
            end
            if (push0) slots[wrPtr] <= pushEntry0;
            if (push1) slots[wrPtr + PTR_W'(1)] <= pushEntry1;
            wrPtr <= wrPtr + PTR_W'(push0) + PTR_W'(push1);
            count <= count + (PTR_W+1)'(push0) + (PTR_W+1)'(push1) - (PTR_W+1)'(pop);
        end
    end

    assign head = slots[rdPtrQ];

    always_comb begin
        entryValid = '0;
        entryReg   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entryValid[i] = slots[i].valid;
            entryReg[i]   = slots[i].regIdx;
        end
    end

`ifdef WB_BYPASS_EN
    assign rdPtr = rdPtrQ;

    always_comb begin
        entryData = '0;
        for (int i = 0; i < DEPTH; i++) entryData[i] = slots[i].data;
    end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register-file write side: accepts ALU and load results, queues them in
// order and issues one register-file write per cycle, with a per-register
// pending scoreboard for decode stalls.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data     ALU result offer; alu_ready = accepted
//   mem_valid/mem_reg/mem_data     load result offer; mem_ready = accepted
//   wb_stall                       hold the queue head, issue no write
//   PVSWriteEn/RegWrite            one-cycle write strobes
//   writeReg/writeData             write address/data, held between writes
//   pending                        bit r set while a write to r is queued or on the port
//   count                          occupied queue entries
// Optional feature WB_BYPASS_EN adds byp_reg -> byp_hit/byp_data, returning the
// youngest outstanding write to byp_reg in the same cycle.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [1:0]            alu_reg,
    input  logic [SIZE_WORD-1:0]  alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [1:0]            mem_reg,
    input  logic [SIZE_WORD-1:0]  mem_data,
    output logic                  mem_ready,
    input  logic                  wb_stall,
    output logic                  PVSWriteEn,
    output logic                  RegWrite,
    output logic [1:0]            writeReg,
    output logic [SIZE_WORD-1:0]  writeData,
    output logic [SIZE_REG-1:0]   pending,
    output logic [PTR_W:0]        count
`ifdef WB_BYPASS_EN
    ,
    input  logic [1:0]            byp_reg,
    output logic                  byp_hit,
    output logic [SIZE_WORD-1:0]  byp_data
`endif
);

    localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO = (PTR_W+1)'(2);

    wbEntry_t                          head;
    wbEntry_t                          pushEntry0;
    wbEntry_t                          pushEntry1;
    logic [DEPTH-1:0]                  entryValid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  entryReg;
    logic                              pop;
    logic                              memAcc;
    logic                              aluAcc;
    logic [PTR_W:0]                    freeSlots;

    // head.valid is equivalent to a non-empty queue.
    assign pop       = head.valid && !wb_stall;
    // The slot popped this cycle is already available to a push.
    assign freeSlots = (PTR_W+1)'(DEPTH) - count + (PTR_W+1)'(pop);

    assign mem_ready = freeSlots >= ONE;
    assign alu_ready = (freeSlots >= TWO) || ((freeSlots >= ONE) && !mem_valid);
    assign memAcc    = mem_valid && mem_ready;
    assign aluAcc    = alu_valid && alu_ready;

    // A load accepted alongside an ALU result goes in first.
    always_comb begin
        pushEntry0 = memAcc ? '{valid: 1'b1, regIdx: mem_reg, data: mem_data}
                            : '{valid: 1'b1, regIdx: alu_reg, data: alu_data};
        pushEntry1 = '{valid: 1'b1, regIdx: alu_reg, data: alu_data};
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0]                  rdPtr;
    logic [DEPTH-1:0][SIZE_WORD-1:0]   entryData;
`endif

    wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uQueue (
        .clk        (clk),
        .reset      (reset),
        .push0      (memAcc || aluAcc),
        .pushEntry0 (pushEntry0),
        .push1      (memAcc && aluAcc),
        .pushEntry1 (pushEntry1),
        .pop        (pop),
        .head       (head),
        .entryValid (entryValid),
        .entryReg   (entryReg),
        .count      (count)
`ifdef WB_BYPASS_EN
        ,
        .rdPtr      (rdPtr),
        .entryData  (entryData)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            PVSWriteEn <= 1'b0;
            RegWrite   <= 1'b0;
            writeReg   <= '0;
            writeData  <= '0;
        end else begin
            PVSWriteEn <= pop;
            RegWrite   <= pop;
            if (pop) begin
                writeReg  <= head.regIdx;
                writeData <= head.data;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) pending = pending | regOneHot(entryReg[i]);
        end
        if (RegWrite) pending = pending | regOneHot(writeReg);
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] slot;

    // The write on the port is the oldest; walking the queue from head to
    // tail lets the youngest match overwrite earlier ones.
    always_comb begin
        byp_hit  = pending[byp_reg];
        byp_data = '0;
        slot     = '0;
        if (RegWrite && (writeReg == byp_reg)) byp_data = writeData;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rdPtr + PTR_W'(i);
            if (entryValid[slot] && (entryReg[slot] == byp_reg)) byp_data = entryData[slot];
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, wb_stall;
    logic [1:0]  alu_reg, mem_reg;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        PVSWriteEn, RegWrite;
    logic [1:0]  writeReg;
    logic [15:0] writeData;
    logic [3:0]  pending;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [1:0]  byp_reg;
    logic        byp_hit;
    logic [15:0] byp_data;
`endif

    reg_writeback dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall),
        .PVSWriteEn(PVSWriteEn), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .pending(pending), .count(count)
`ifdef WB_BYPASS_EN
        , .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of outstanding writes plus the port state.
    typedef struct {
        logic [1:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic        portV    = 1'b0;
    logic [1:0]  portReg  = '0;
    logic [15:0] portData = '0;
    logic [15:0] rf[4];

    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        bit          mv; logic [1:0] mr; logic [15:0] md;
        bit          av; logic [1:0] ar; logic [15:0] ad;
        bit          st;
        bit          eMemRdy, eAluRdy;
        int          eCnt;
        bit          eStrb;
        logic [1:0]  eReg;
        logic [15:0] eData;
        logic [3:0]  ePend;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int modelFree();
        return 4 - q.size() + ((q.size() > 0 && !wb_stall) ? 1 : 0);
    endfunction

    task automatic drive(input bit mv, input logic [1:0] mr, input logic [15:0] md,
                         input bit av, input logic [1:0] ar, input logic [15:0] ad, input bit st);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        wb_stall  = st;
    endtask

    task automatic modelCheck();
        int         fr;
        logic [3:0] pend;
        fr   = modelFree();
        pend = '0;
        foreach (q[i]) pend[q[i].r] = 1'b1;
        if (portV) pend[portReg] = 1'b1;
        chk("mem_ready", mem_ready, (fr >= 1));
        chk("alu_ready", alu_ready, (fr >= 2) || (fr >= 1 && !mem_valid));
        chk("count", count, q.size());
        chk("PVSWriteEn", PVSWriteEn, portV);
        chk("RegWrite", RegWrite, portV);
        chk("writeReg", writeReg, portReg);
        chk("writeData", writeData, portData);
        chk("pending", pending, pend);
`ifdef WB_BYPASS_EN
        begin
            bit          hit;
            logic [15:0] bd;
            hit = 1'b0; bd = '0;
            if (portV && portReg == byp_reg) begin hit = 1'b1; bd = portData; end
            foreach (q[i]) if (q[i].r == byp_reg) begin hit = 1'b1; bd = q[i].d; end
            chk("byp_hit", byp_hit, hit);
            if (hit) chk("byp_data", byp_data, bd);
        end
`endif
    endtask

    // Called at the negedge; advances the model across the next posedge.
    task automatic stepEdge();
        int   fr;
        bit   doPop, mAcc, aAcc;
        ent_t e;
        if (RegWrite) rf[writeReg] = writeData;
        fr    = modelFree();
        doPop = (q.size() > 0) && !wb_stall;
        mAcc  = mem_valid && (fr >= 1);
        aAcc  = alu_valid && ((fr >= 2) || (fr >= 1 && !mem_valid));
        @(posedge clk);
        if (reset) begin
            q.delete();
            portV = 1'b0; portReg = '0; portData = '0;
        end else begin
            if (doPop) begin
                e = q.pop_front();
                portV = 1'b1; portReg = e.r; portData = e.d;
            end else begin
                portV = 1'b0;
            end
            if (mAcc) q.push_back('{r: mem_reg, d: mem_data});
            if (aAcc) q.push_back('{r: alu_reg, d: alu_data});
        end
        #1;
    endtask

    task automatic cycle(input bit mv, input logic [1:0] mr, input logic [15:0] md,
                         input bit av, input logic [1:0] ar, input logic [15:0] ad, input bit st);
        drive(mv, mr, md, av, ar, ad, st);
        @(negedge clk);
        modelCheck();
        stepEdge();
    endtask

    function automatic vec_t mk(input bit mv, input logic [1:0] mr, input logic [15:0] md,
                                input bit av, input logic [1:0] ar, input logic [15:0] ad, input bit st,
                                input bit emr, input bit ear, input int ec, input bit es,
                                input logic [1:0] er, input logic [15:0] ed, input logic [3:0] ep);
        vec_t v;
        v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad; v.st = st;
        v.eMemRdy = emr; v.eAluRdy = ear; v.eCnt = ec; v.eStrb = es;
        v.eReg = er; v.eData = ed; v.ePend = ep;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = '0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
        byp_reg = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write latency, stalled fill to full, full pop+push, drain.
        vecs[0]  = mk(0,0,16'h00, 1,2,16'h05, 0,  1,1,0, 0,0,16'h00, 4'h0);
        vecs[1]  = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,1, 0,0,16'h00, 4'h4);
        vecs[2]  = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,0, 1,2,16'h05, 4'h4);
        vecs[3]  = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,0, 0,2,16'h05, 4'h0);
        vecs[4]  = mk(1,0,16'h10, 1,1,16'h11, 1,  1,1,0, 0,2,16'h05, 4'h0);
        vecs[5]  = mk(1,2,16'h12, 1,3,16'h13, 1,  1,1,2, 0,2,16'h05, 4'h3);
        vecs[6]  = mk(1,0,16'h20, 1,0,16'h21, 1,  0,0,4, 0,2,16'h05, 4'hF);
        vecs[7]  = mk(1,1,16'h30, 1,2,16'h31, 0,  1,0,4, 0,2,16'h05, 4'hF);
        vecs[8]  = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,4, 1,0,16'h10, 4'hF);
        vecs[9]  = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,3, 1,1,16'h11, 4'hE);
        vecs[10] = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,2, 1,2,16'h12, 4'hE);
        vecs[11] = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,1, 1,3,16'h13, 4'hA);
        vecs[12] = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,0, 1,1,16'h30, 4'h2);
        vecs[13] = mk(0,0,16'h00, 0,0,16'h00, 0,  1,1,0, 0,1,16'h30, 4'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].st);
            @(negedge clk);
            chk($sformatf("vec%0d mem_ready", i), mem_ready, vecs[i].eMemRdy);
            chk($sformatf("vec%0d alu_ready", i), alu_ready, vecs[i].eAluRdy);
            chk($sformatf("vec%0d count", i), count, vecs[i].eCnt);
            chk($sformatf("vec%0d PVSWriteEn", i), PVSWriteEn, vecs[i].eStrb);
            chk($sformatf("vec%0d RegWrite", i), RegWrite, vecs[i].eStrb);
            chk($sformatf("vec%0d writeReg", i), writeReg, vecs[i].eReg);
            chk($sformatf("vec%0d writeData", i), writeData, vecs[i].eData);
            chk($sformatf("vec%0d pending", i), pending, vecs[i].ePend);
            modelCheck();
            stepEdge();
        end

        // Load and ALU result for the same register in one cycle: load first, ALU wins.
        cycle(1, 1, 16'h00AA, 1, 1, 16'h0011, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("same-reg first write", {RegWrite, writeData}, {1'b1, 16'h00AA});
        modelCheck(); stepEdge();
        @(negedge clk);
        chk("same-reg second write", {RegWrite, writeData}, {1'b1, 16'h0011});
        modelCheck(); stepEdge();
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("rf r1 final", rf[1], 16'h0011);

        // Reset while draining with three entries still queued.
        cycle(1, 0, 16'h0101, 1, 1, 16'h0102, 1);
        cycle(1, 2, 16'h0103, 1, 3, 16'h0104, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset count", count, 3);
        chk("pre-reset strobe", RegWrite, 1);
        reset = 1'b1;
        stepEdge();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset count", count, 0);
        chk("post-reset pending", pending, 0);
        chk("post-reset strobes", {PVSWriteEn, RegWrite}, 2'b00);
        modelCheck(); stepEdge();

`ifdef WB_BYPASS_EN
        // Two queued writes to r3: bypass returns the younger.
        byp_reg = 2'd3;
        cycle(0, 0, 0, 1, 3, 16'h0001, 1);
        cycle(0, 0, 0, 1, 3, 16'h0002, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("byp youngest hit", byp_hit, 1);
        chk("byp youngest data", byp_data, 16'h0002);
        modelCheck(); stepEdge();
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
`ifdef WB_BYPASS_EN
            byp_reg = 2'($urandom_range(0, 3));
`endif
            reset = ($urandom_range(0, 59) == 0);
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                  ($urandom_range(0, 9) < 3));
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
